// File: rtl/imem_fetch_responder_if.sv
// Instruction-fetch bus between the core front end (master) and the fetch responder (slave).
// Also carries the word-write load port used by benches and boot logic.
interface imem_fetch_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] rsp_addr;
  logic        flush;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  modport master (
    output req_valid, req_addr, rsp_ready, flush, ld_we, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_addr
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, flush, ld_we, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_data, rsp_err, rsp_addr
  );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction memory responder: one outstanding fetch, fixed wait-state latency,
// redirect flush and a word-write load port.
module imem_fetch_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] ERR_WORD    = 32'h00000013
) (
  input logic                   clk,
  input logic                   rst_n,
  imem_fetch_responder_if.slave bus
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = 4;

  if ((LATENCY < 1) || (LATENCY > 15)) begin : g_latency_check
    $error("imem_fetch_responder: LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic [31:0]   rsp_addr_q, rsp_addr_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          req_ready_c;
  logic          accept_c;
  logic          addr_err_c;
  logic [31:0]   mem_rd_c;
  logic          ld_addr_lsb_unused;

  assign req_ready_c = !bus.flush &&
                       ((state_q == S_IDLE) || ((state_q == S_RESP) && bus.rsp_ready));
  assign accept_c    = bus.req_valid && req_ready_c;
  assign addr_err_c  = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH_WORDS));
  // Read sees the pre-edge word, so a same-edge load-port write returns the old value.
  assign mem_rd_c    = mem[addr_q[AW+1:2]];
  assign ld_addr_lsb_unused = ^bus.ld_addr[1:0];

  always_comb begin : p_next
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;

    if (bus.flush) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      rsp_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = addr_err_c;
            rsp_data_d  = addr_err_c ? ERR_WORD : mem_rd_c;
            rsp_addr_d  = addr_q;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // A new accept overrides the handshake return to IDLE.
      if (accept_c) begin
        state_d = S_WAIT;
        cnt_d   = CW'(LATENCY - 1);
        addr_d  = bus.req_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_regs
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

  // Memory contents survive reset; out-of-range loads are dropped.
  always_ff @(posedge clk) begin : p_mem_wr
    if (bus.ld_we && (bus.ld_addr[31:2] < 30'(DEPTH_WORDS))) begin
      mem[bus.ld_addr[AW+1:2]] <= bus.ld_data;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_addr  = rsp_addr_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder: latency, stall, streaming, errors, flush,
// load-port collisions and mid-transaction reset.
module tb_imem_fetch_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam logic [31:0] W0     = 32'h00500093;
  localparam logic [31:0] W1     = 32'h00a00113;
  localparam logic [31:0] W2     = 32'h002081b3;
  localparam logic [31:0] W_LAST = 32'hcafef00d;
  localparam logic [31:0] W_OLD  = 32'h11111111;
  localparam logic [31:0] W_NEW  = 32'h22222222;
  localparam logic [31:0] W4_A   = 32'h33333333;
  localparam logic [31:0] W4_B   = 32'h44444444;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  imem_fetch_responder_if bus ();

  imem_fetch_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT),
    .ERR_WORD   (NOP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.ld_we = 1'b1; bus.ld_addr = a; bus.ld_data = d;
    @(negedge clk);
    bus.ld_we = 1'b0;
  endtask

  // Issue one request from IDLE; returns at the negedge after the response edge.
  task automatic issue(input logic [31:0] a);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = a;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.rsp_ready = 1'b0; bus.flush = 1'b0;
    bus.ld_we = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.rsp_valid, bus.rsp_err} !== 2'b00) begin
      n_err++; $display("FAIL reset_flags: got %b expected 00", {bus.rsp_valid, bus.rsp_err});
    end
    n_vec++;
    if (bus.rsp_data !== 32'h0) begin
      n_err++; $display("FAIL reset_data: got %h expected 00000000", bus.rsp_data);
    end
    n_vec++;
    if (bus.rsp_addr !== 32'h0) begin
      n_err++; $display("FAIL reset_addr: got %h expected 00000000", bus.rsp_addr);
    end
    n_vec++;
    if (bus.req_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    load_word(32'd0, W0);
    load_word(32'd4, W1);
    load_word(32'd8, W2);
    load_word(32'd4092, W_LAST);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 32'd0;
    n_vec++;
    if (bus.req_ready !== 1'b1) begin
      n_err++; $display("FAIL basic_req_ready: got %b expected 1", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_vec++;
    if (bus.rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_early_n: got %b expected 0", bus.rsp_valid);
    end
    @(negedge clk);
    n_vec++;
    if (bus.rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_early_n1: got %b expected 0", bus.rsp_valid);
    end
    @(negedge clk);
    n_vec++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_addr} !== {1'b1, 1'b0, W0, 32'd0}) begin
      n_err++;
      $display("FAIL basic_rsp: got v=%b e=%b d=%h a=%h expected v=1 e=0 d=%h a=00000000",
               bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_addr, W0);
    end
    @(negedge clk);
    n_vec++;
    if (bus.rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_consumed: got %b expected 0", bus.rsp_valid);
    end
  endtask

  task automatic test_stall();
    bus.rsp_ready = 1'b0;
    issue(32'd4);
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if ({bus.rsp_valid, bus.rsp_data, bus.req_ready} !== {1'b1, W1, 1'b0}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got v=%b d=%h rdy=%b expected v=1 d=%h rdy=0",
                 i, bus.rsp_valid, bus.rsp_data, bus.req_ready, W1);
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_release: got %b expected 0", bus.rsp_valid);
    end
  endtask

  // Next accept coincides with the handshake edge, so responses are LAT+1 cycles apart.
  task automatic test_stream();
    logic [31:0] exp_d [3];
    int   nxt, got, last_c;
    logic acc;
    exp_d[0] = W0; exp_d[1] = W1; exp_d[2] = W2;
    nxt = 0; got = 0; last_c = 0;
    @(negedge clk);
    bus.rsp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'd0;
    for (int c = 0; c < 14; c++) begin
      if (bus.rsp_valid === 1'b1) begin
        n_vec++;
        if (got > 2) begin
          n_err++; $display("FAIL stream_extra: got response a=%h expected none", bus.rsp_addr);
        end else if ({bus.rsp_addr, bus.rsp_data} !== {32'(4 * got), exp_d[got]}) begin
          n_err++;
          $display("FAIL stream_rsp[%0d]: got a=%h d=%h expected a=%h d=%h",
                   got, bus.rsp_addr, bus.rsp_data, 32'(4 * got), exp_d[got]);
        end
        if (got > 0) begin
          n_vec++;
          if (c - last_c != int'(LAT) + 1) begin
            n_err++; $display("FAIL stream_gap: got %0d expected %0d", c - last_c, int'(LAT) + 1);
          end
        end
        last_c = c;
        got++;
      end
      acc = bus.req_valid && bus.req_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        nxt++;
        bus.req_valid = (nxt < 3);
        bus.req_addr  = 32'(4 * nxt);
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    n_vec++;
    if (got != 3) begin
      n_err++; $display("FAIL stream_count: got %0d expected 3", got);
    end
  endtask

  task automatic test_errors();
    bus.rsp_ready = 1'b1;
    issue(32'h2);
    n_vec++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_addr} !== {1'b1, 1'b1, NOP, 32'h2}) begin
      n_err++;
      $display("FAIL err_misaligned: got v=%b e=%b d=%h a=%h expected v=1 e=1 d=%h a=00000002",
               bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_addr, NOP);
    end
    issue(32'(4 * DEPTH));
    n_vec++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_addr} !== {1'b1, 1'b1, NOP, 32'(4 * DEPTH)}) begin
      n_err++;
      $display("FAIL err_range: got v=%b e=%b d=%h a=%h expected v=1 e=1 d=%h a=%h",
               bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_addr, NOP, 32'(4 * DEPTH));
    end
    issue(32'd4092);
    n_vec++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {1'b1, 1'b0, W_LAST}) begin
      n_err++;
      $display("FAIL last_word: got v=%b e=%b d=%h expected v=1 e=0 d=%h",
               bus.rsp_valid, bus.rsp_err, bus.rsp_data, W_LAST);
    end
    load_word(32'(4 * DEPTH), 32'hdeadbeef);
    issue(32'd0);
    n_vec++;
    if (bus.rsp_data !== W0) begin
      n_err++; $display("FAIL ld_out_of_range: got %h expected %h", bus.rsp_data, W0);
    end
  endtask

  task automatic test_flush();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 32'd0;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.flush = 1'b1;
    n_vec++;
    if (bus.req_ready !== 1'b0) begin
      n_err++; $display("FAIL flush_req_ready: got %b expected 0", bus.req_ready);
    end
    @(negedge clk);
    bus.flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (bus.rsp_valid !== 1'b0) begin
        n_err++; $display("FAIL flush_wait_drop[%0d]: got %b expected 0", i, bus.rsp_valid);
      end
      @(negedge clk);
    end

    bus.rsp_ready = 1'b0;
    issue(32'd4);
    n_vec++;
    if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, W1}) begin
      n_err++; $display("FAIL flush_pre_resp: got v=%b d=%h expected v=1 d=%h",
                        bus.rsp_valid, bus.rsp_data, W1);
    end
    bus.flush = 1'b1; bus.rsp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'd0;
    n_vec++;
    if (bus.req_ready !== 1'b0) begin
      n_err++; $display("FAIL flush_resp_ready: got %b expected 0", bus.req_ready);
    end
    @(negedge clk);
    bus.flush = 1'b0; bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (bus.rsp_valid !== 1'b0) begin
        n_err++; $display("FAIL flush_resp_drop[%0d]: got %b expected 0", i, bus.rsp_valid);
      end
      @(negedge clk);
    end

    issue(32'd8);
    n_vec++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_addr} !== {1'b1, 1'b0, W2, 32'd8}) begin
      n_err++;
      $display("FAIL flush_next: got v=%b e=%b d=%h a=%h expected v=1 e=0 d=%h a=00000008",
               bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_addr, W2);
    end
  endtask

  task automatic test_collision();
    bus.rsp_ready = 1'b1;
    load_word(32'd12, W_OLD);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 32'd12;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    bus.ld_we = 1'b1; bus.ld_addr = 32'd12; bus.ld_data = W_NEW;
    @(negedge clk);
    bus.ld_we = 1'b0;
    n_vec++;
    if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, W_OLD}) begin
      n_err++; $display("FAIL collide_old: got v=%b d=%h expected v=1 d=%h",
                        bus.rsp_valid, bus.rsp_data, W_OLD);
    end
    issue(32'd12);
    n_vec++;
    if (bus.rsp_data !== W_NEW) begin
      n_err++; $display("FAIL collide_new: got %h expected %h", bus.rsp_data, W_NEW);
    end

    load_word(32'd16, W4_A);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 32'd16;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.ld_we = 1'b1; bus.ld_addr = 32'd16; bus.ld_data = W4_B;
    @(negedge clk);
    bus.ld_we = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, W4_B}) begin
      n_err++; $display("FAIL wait_write: got v=%b d=%h expected v=1 d=%h",
                        bus.rsp_valid, bus.rsp_data, W4_B);
    end
  endtask

  task automatic test_reset_mid();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 32'd4;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++;
    if (bus.rsp_data !== 32'h0) begin
      n_err++; $display("FAIL midreset_data: got %h expected 00000000", bus.rsp_data);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (bus.rsp_valid !== 1'b0) begin
        n_err++; $display("FAIL midreset_no_rsp[%0d]: got %b expected 0", i, bus.rsp_valid);
      end
      @(negedge clk);
    end
    issue(32'd0);
    n_vec++;
    if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, W0}) begin
      n_err++; $display("FAIL midreset_mem_kept: got v=%b d=%h expected v=1 d=%h",
                        bus.rsp_valid, bus.rsp_data, W0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_stream();
    test_errors();
    test_flush();
    test_collision();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
